// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline hazard control bundle: hazard inputs from the pipe, stage enables,
// flush controls and event counters going back.
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              idex_mem_read;
    logic [REG_AW-1:0] idex_rt;
    logic [REG_AW-1:0] ifid_rs;
    logic [REG_AW-1:0] ifid_rt;
    logic              ifid_uses_rt;
    logic              branch_taken;
    logic              mem_busy;
    logic              cnt_clr;

    logic              pc_write;
    logic              ifid_write;
    logic              idex_write;
    logic              exmem_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              exmem_flush;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  freeze_cnt;
    logic [CNT_W-1:0]  redir_cnt;

    modport master (
        output idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
        output branch_taken, mem_busy, cnt_clr,
        input  pc_write, ifid_write, idex_write, exmem_write,
        input  ifid_flush, idex_bubble, exmem_flush,
        input  state_o, stall_cnt, freeze_cnt, redir_cnt
    );

    modport slave (
        input  idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
        input  branch_taken, mem_busy, cnt_clr,
        output pc_write, ifid_write, idex_write, exmem_write,
        output ifid_flush, idex_bubble, exmem_flush,
        output state_o, stall_cnt, freeze_cnt, redir_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: load-use stall, memory freeze and multi-cycle branch
// redirect, with saturating performance event counters.
module hazard_ctrl_unit #(
    parameter int unsigned REG_AW          = 5,
    parameter int unsigned BR_FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_ctrl_unit_if.slave  hz
);
    localparam int unsigned RdW = (BR_FLUSH_CYCLES > 1) ? $clog2(BR_FLUSH_CYCLES) : 1;
    localparam logic [RdW-1:0] RdInit = RdW'(BR_FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun      = 2'b00,
        StFreeze   = 2'b01,
        StRedirect = 2'b10
    } state_e;

    state_e           state_q, state_d, eff_state;
    logic [RdW-1:0]   rd_cnt_q, rd_cnt_d;
    logic             resume_q, resume_d;
    logic [CNT_W-1:0] stall_q, freeze_q, redir_q;
    logic             load_use, stall_ev, redir_ev;

    assign load_use = hz.idex_mem_read && (hz.idex_rt != '0) &&
                      ((hz.idex_rt == hz.ifid_rs) ||
                       (hz.ifid_uses_rt && (hz.idex_rt == hz.ifid_rt)));

    // Leaving FREEZE acts as the resume target in the same cycle.
    assign eff_state = (state_q == StFreeze) ? (resume_q ? StRedirect : StRun) : state_q;

    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.idex_write  = 1'b1;
        hz.exmem_write = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_bubble = 1'b0;
        hz.exmem_flush = 1'b0;
        state_d        = state_q;
        rd_cnt_d       = rd_cnt_q;
        resume_d       = resume_q;
        stall_ev       = 1'b0;
        redir_ev       = 1'b0;

        if (hz.mem_busy) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            state_d        = StFreeze;
            if (state_q == StRedirect) begin
                resume_d = (rd_cnt_q != '0);
            end else if (state_q == StRun) begin
                resume_d = 1'b0;
            end
        end else if (hz.branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
            hz.exmem_flush = 1'b1;
            rd_cnt_d       = RdInit;
            state_d        = (RdInit != '0) ? StRedirect : StRun;
            resume_d       = 1'b0;
            redir_ev       = 1'b1;
        end else if (eff_state == StRedirect) begin
            // IF/ID still holds a wrong-path fetch, so load_use is meaningless here.
            hz.ifid_flush = 1'b1;
            rd_cnt_d      = (rd_cnt_q != '0) ? rd_cnt_q - RdW'(1) : '0;
            state_d       = (rd_cnt_q <= RdW'(1)) ? StRun : StRedirect;
            resume_d      = 1'b0;
        end else begin
            state_d  = StRun;
            resume_d = 1'b0;
            if (load_use) begin
                hz.pc_write    = 1'b0;
                hz.ifid_write  = 1'b0;
                hz.idex_bubble = 1'b1;
                stall_ev       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            rd_cnt_q <= '0;
            resume_q <= 1'b0;
            stall_q  <= '0;
            freeze_q <= '0;
            redir_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            resume_q <= resume_d;
            // Clear beats a same-cycle event; counters stick at all-ones.
            if (hz.cnt_clr) begin
                stall_q  <= '0;
                freeze_q <= '0;
                redir_q  <= '0;
            end else begin
                if (stall_ev && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
                if (hz.mem_busy && (freeze_q != '1)) freeze_q <= freeze_q + CNT_W'(1);
                if (redir_ev && (redir_q != '1)) redir_q <= redir_q + CNT_W'(1);
            end
        end
    end

    assign hz.state_o    = state_q;
    assign hz.stall_cnt  = stall_q;
    assign hz.freeze_cnt = freeze_q;
    assign hz.redir_cnt  = redir_q;
endmodule
